// File: rtl/ac_alu_datapath.sv
// Accumulator datapath: 16-bit AC, E flag, opcode decoder, and a combinational ALU
// offering AND, integer/binary16-float ADD, DR pass-through and INPR load.
module ac_alu_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ir_opcode,
    output logic [7:0]       d,
    input  logic [WIDTH-1:0] dr,
    input  logic [7:0]       inpr,
    input  logic [1:0]       alu_sel,
    input  logic             float_flag,
    input  logic             ld,
    input  logic             inc,
    input  logic             clr,
    input  logic             cma,
    input  logic             cme,
    input  logic             cir,
    input  logic             cil,
    input  logic             cle,
    output logic [WIDTH-1:0] ac,
    output logic             e,
    output logic [WIDTH-1:0] alu_result
);

    logic        alu_e;

    logic        sa, sb, sbig, sub, a_big;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [4:0]  ea, eb, ebig, esml, ediff;
    logic [9:0]  fa, fb, fbig, fsml;
    logic [13:0] mbig, msml_full, msml, smask;
    logic        sticky;
    logic [14:0] fsum;
    logic [13:0] norm;
    logic [3:0]  lead, shamt;
    logic [15:0] fp_res;

    assign d = 8'b0000_0001 << ir_opcode;

    // Binary16 add, truncating. Mantissas carry three guard bits plus a sticky
    // LSB so that truncating the normalised sum equals truncating the exact sum.
    always_comb begin
        sa = ac[15];
        ea = ac[14:10];
        fa = ac[9:0];
        sb = dr[15];
        eb = dr[14:10];
        fb = dr[9:0];

        a_nan  = (ea == 5'h1F) && (fa != '0);
        b_nan  = (eb == 5'h1F) && (fb != '0);
        a_inf  = (ea == 5'h1F) && (fa == '0);
        b_inf  = (eb == 5'h1F) && (fb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        a_big = {ea, fa} >= {eb, fb};
        sbig  = a_big ? sa : sb;
        ebig  = a_big ? ea : eb;
        fbig  = a_big ? fa : fb;
        esml  = a_big ? eb : ea;
        fsml  = a_big ? fb : fa;
        sub   = sa ^ sb;
        ediff = ebig - esml;

        mbig      = {1'b1, fbig, 3'b000};
        msml_full = {1'b1, fsml, 3'b000};
        smask     = (ediff >= 5'd14) ? '1 : ((14'd1 << ediff) - 14'd1);
        sticky    = |(msml_full & smask);
        msml      = (msml_full >> ediff) | {13'b0, sticky};
        fsum      = sub ? ({1'b0, mbig} - {1'b0, msml}) : ({1'b0, mbig} + {1'b0, msml});

        lead = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (fsum[i]) lead = 4'(i);
        end
        shamt = 4'd13 - lead;
        norm  = fsum[13:0] << shamt;

        fp_res = '0;
        if (a_nan || b_nan)
            fp_res = 16'h7E00;
        else if (a_inf && b_inf)
            fp_res = (sa != sb) ? 16'h7E00 : {sa, 5'h1F, 10'h000};
        else if (a_inf)
            fp_res = {sa, 5'h1F, 10'h000};
        else if (b_inf)
            fp_res = {sb, 5'h1F, 10'h000};
        else if (a_zero && b_zero)
            fp_res = '0;
        else if (a_zero)
            fp_res = dr[15:0];
        else if (b_zero)
            fp_res = ac[15:0];
        else if (fsum == '0)
            fp_res = '0;
        else if (fsum[14])
            fp_res = (ebig == 5'd30) ? {sbig, 5'h1F, 10'h000} : {sbig, ebig + 5'd1, fsum[13:4]};
        else if ({1'b0, ebig} <= {2'b00, shamt})
            fp_res = '0;
        else
            fp_res = {sbig, ebig - {1'b0, shamt}, norm[12:3]};
    end

    always_comb begin
        alu_result = '0;
        alu_e      = e;
        case (alu_sel)
            2'b00: alu_result = ac & dr;
            2'b01: begin
                if (float_flag) begin
                    alu_result = WIDTH'(fp_res);
                    alu_e      = 1'b0;
                end else begin
                    {alu_e, alu_result} = {1'b0, ac} + {1'b0, dr};
                end
            end
            2'b10: alu_result = dr;
            default: alu_result = {ac[WIDTH-1:8], inpr};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ac <= '0;
            e  <= 1'b0;
        end else begin
            if (clr)      ac <= '0;
            else if (ld)  ac <= alu_result;
            else if (inc) ac <= ac + 1'b1;
            else if (cma) ac <= ~ac;
            else if (cir) ac <= {e, ac[WIDTH-1:1]};
            else if (cil) ac <= {ac[WIDTH-2:0], e};

            // A rotate only moves E when it is also the operation that wins AC.
            if (ld)                                  e <= alu_e;
            else if (cir && !(clr || inc || cma))    e <= ac[0];
            else if (cil && !(clr || inc || cma))    e <= ac[WIDTH-1];
            else if (cle)                            e <= 1'b0;
            else if (cme)                            e <= ~e;
        end
    end

endmodule

// File: tb/tb_ac_alu_datapath.sv
// Self-checking bench for ac_alu_datapath: directed scenarios plus randomized
// stimulus compared against an arithmetic reference model.
module tb_ac_alu_datapath;

    logic        clk = 1'b0;
    logic        reset, float_flag, ld, inc, clr, cma, cme, cir, cil, cle;
    logic [2:0]  ir_opcode;
    logic [7:0]  d, inpr;
    logic [15:0] dr, ac, alu_result;
    logic [1:0]  alu_sel;
    logic        e;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_ac;
    logic        m_e;

    always #5 clk = ~clk;

    ac_alu_datapath #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .ir_opcode(ir_opcode), .d(d), .dr(dr), .inpr(inpr),
        .alu_sel(alu_sel), .float_flag(float_flag), .ld(ld), .inc(inc), .clr(clr),
        .cma(cma), .cme(cme), .cir(cir), .cil(cil), .cle(cle), .ac(ac), .e(e),
        .alu_result(alu_result)
    );

    // Exact value of each operand in units of 2^-24, summed, then re-encoded with truncation.
    function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b);
        longint va, vb, sum, mag;
        int p, be;
        logic [63:0] q;
        logic sgn;
        if ((a[14:10] == 5'h1F && a[9:0] != 0) || (b[14:10] == 5'h1F && b[9:0] != 0)) return 16'h7E00;
        if (a[14:10] == 5'h1F && b[14:10] == 5'h1F) return (a[15] != b[15]) ? 16'h7E00 : a;
        if (a[14:10] == 5'h1F) return a;
        if (b[14:10] == 5'h1F) return b;
        va = (a[14:10] == 0) ? 0 : (longint'({1'b1, a[9:0]}) << (int'(a[14:10]) - 1));
        vb = (b[14:10] == 0) ? 0 : (longint'({1'b1, b[9:0]}) << (int'(b[14:10]) - 1));
        if (a[15]) va = -va;
        if (b[15]) vb = -vb;
        sum = va + vb;
        if (sum == 0) return 16'h0000;
        sgn = (sum < 0);
        mag = sgn ? -sum : sum;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        be = p - 9;
        if (be <= 0) return 16'h0000;
        if (be >= 31) return {sgn, 5'h1F, 10'h000};
        q = mag;
        q = (p >= 10) ? (q >> (p - 10)) : (q << (10 - p));
        return {sgn, be[4:0], q[9:0]};
    endfunction

    // Returns {alu_e, alu_result}.
    function automatic logic [16:0] alu_model(input logic [15:0] a, input logic ee, input logic [15:0] b,
                                              input logic [7:0] in8, input logic [1:0] sel, input logic ff);
        case (sel)
            2'd0:    return {ee, a & b};
            2'd1:    return ff ? {1'b0, fp_model(a, b)} : ({1'b0, a} + {1'b0, b});
            2'd2:    return {ee, b};
            default: return {ee, a[15:8], in8};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        reset = 0; ld = 0; inc = 0; clr = 0; cma = 0; cme = 0; cir = 0; cil = 0; cle = 0;
        float_flag = 0;
    endtask

    task automatic load_ac(input logic [15:0] v);
        idle();
        alu_sel = 2'b10; dr = v; ld = 1;
        tick();
        ld = 0;
    endtask

    task automatic set_e(input logic v);
        idle();
        cle = 1;
        tick();
        cle = 0;
        if (v) begin
            cme = 1;
            tick();
            cme = 0;
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] xac, input logic xe);
        checks++;
        if (ac !== xac || e !== xe) begin
            errors++;
            $display("FAIL %s: ac=%h e=%b, expected ac=%h e=%b", name, ac, e, xac, xe);
        end
    endtask

    task automatic test_reset;
        idle();
        reset = 1; ld = 1; inc = 1; cme = 1; cil = 1;
        alu_sel = 2'b01; dr = 16'hFFFF; inpr = 8'hA5;
        tick();
        checks++;
        if (ac !== 16'h0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset: ac=%h e=%b, expected ac=0000 e=0", ac, e);
        end
        load_ac(16'h1234);
        set_e(1);
        idle();
        reset = 1; ld = 1; alu_sel = 2'b01; dr = 16'h4321; cme = 1; inc = 1;
        tick();
        checks++;
        if (ac !== 16'h0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_override: ac=%h e=%b, expected ac=0000 e=0", ac, e);
        end
        idle();
    endtask

    task automatic test_decoder;
        logic [7:0] table_d [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int op = 0; op < 8; op++) begin
            ir_opcode = 3'(op);
            #1;
            checks++;
            if (d !== table_d[op]) begin
                errors++;
                $display("FAIL decoder op=%0d: d=%h, expected %h", op, d, table_d[op]);
            end
        end
    endtask

    task automatic test_int_add_and;
        load_ac(16'hFFFF);
        set_e(0);
        alu_sel = 2'b01; dr = 16'h0001; ld = 1;
        tick();
        ld = 0;
        check_state("int_add_carry", 16'h0000, 1'b1);
        load_ac(16'h1234);
        alu_sel = 2'b00; dr = 16'h00FF; ld = 1;
        tick();
        ld = 0;
        check_state("and_keeps_e", 16'h0034, 1'b1);
    endtask

    task automatic test_float_directed;
        logic [15:0] vec [4][3] = '{'{16'h3C00, 16'h4000, 16'h4200}, '{16'h7BFF, 16'h7BFF, 16'h7C00},
                                    '{16'h3C00, 16'hBC00, 16'h0000}, '{16'h7C00, 16'hFC00, 16'h7E00}};
        for (int i = 0; i < 4; i++) begin
            load_ac(vec[i][0]);
            set_e(1);
            alu_sel = 2'b01; float_flag = 1; dr = vec[i][1]; ld = 1;
            tick();
            idle();
            check_state($sformatf("float_add_%0d", i), vec[i][2], 1'b0);
        end
    endtask

    task automatic test_rotates;
        load_ac(16'h8001);
        set_e(0);
        cir = 1;
        tick();
        cir = 0;
        check_state("cir", 16'h4000, 1'b1);
        cil = 1;
        tick();
        cil = 0;
        check_state("cil", 16'h8001, 1'b0);
    endtask

    task automatic test_priority;
        load_ac(16'h5555);
        clr = 1; ld = 1; alu_sel = 2'b10; dr = 16'h1111;
        tick();
        idle();
        check_state("clr_over_ld", 16'h0000, 1'b0);
        load_ac(16'hAB00);
        alu_sel = 2'b11; inpr = 8'h5C; ld = 1;
        tick();
        ld = 0;
        check_state("inpr_load", 16'hAB5C, 1'b0);
        load_ac(16'hFFFF);
        set_e(1);
        inc = 1;
        tick();
        inc = 0;
        check_state("inc_wrap", 16'h0000, 1'b1);
        cme = 1;
        tick();
        cme = 0;
        check_state("cme", 16'h0000, 1'b0);
        cme = 1;
        tick();
        cme = 0;
        cle = 1;
        tick();
        cle = 0;
        check_state("cme_then_cle", 16'h0000, 1'b0);
    endtask

    task automatic test_float_random;
        logic [15:0] a, b, x;
        int mode;
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom);
            mode = $urandom_range(0, 5);
            case (mode)
                0: b = 16'($urandom);
                1: b = a ^ 16'h8000;
                2: b = {1'($urandom), a[14:10] + 5'($urandom_range(0, 2)) - 5'd1, 10'($urandom)};
                3: begin a[14:10] = 5'($urandom_range(27, 30)); b = {1'($urandom), 5'($urandom_range(27, 30)), 10'($urandom)}; end
                4: begin a[14:10] = 5'($urandom_range(1, 3)); b = {1'($urandom), 5'($urandom_range(1, 3)), 10'($urandom)}; end
                default: b = {1'($urandom), ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00, ($urandom_range(0, 1) == 1) ? 10'h000 : 10'($urandom)};
            endcase
            load_ac(a);
            alu_sel = 2'b01; float_flag = 1; dr = b;
            #1;
            x = fp_model(a, b);
            checks++;
            if (alu_result !== x) begin
                errors++;
                $display("FAIL float_rand %h+%h: alu_result=%h, expected %h", a, b, alu_result, x);
            end
            float_flag = 0;
        end
    endtask

    task automatic test_back_to_back;
        logic [16:0] alu;
        logic [15:0] nac;
        logic ne;
        idle();
        reset = 1;
        tick();
        m_ac = 16'h0000; m_e = 1'b0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 7) == 0);
            ld  = ($urandom_range(0, 3) == 0);
            inc = ($urandom_range(0, 4) == 0);
            cma = ($urandom_range(0, 4) == 0);
            cir = ($urandom_range(0, 3) == 0);
            cil = ($urandom_range(0, 3) == 0);
            cle = ($urandom_range(0, 4) == 0);
            cme = ($urandom_range(0, 2) == 0);
            alu_sel = 2'($urandom);
            float_flag = 1'($urandom);
            dr = 16'($urandom);
            inpr = 8'($urandom);
            ir_opcode = 3'($urandom);
            #1;
            alu = alu_model(m_ac, m_e, dr, inpr, alu_sel, float_flag);
            checks++;
            if (alu_result !== alu[15:0]) begin
                errors++;
                $display("FAIL b2b_alu[%0d]: alu_result=%h, expected %h", n, alu_result, alu[15:0]);
            end
            nac = m_ac; ne = m_e;
            if (reset) begin
                nac = 16'h0000; ne = 1'b0;
            end else begin
                if (clr)      nac = 16'h0000;
                else if (ld)  nac = alu[15:0];
                else if (inc) nac = m_ac + 16'd1;
                else if (cma) nac = ~m_ac;
                else if (cir) nac = {m_e, m_ac[15:1]};
                else if (cil) nac = {m_ac[14:0], m_e};
                if (ld) ne = alu[16];
                else if (cir && !clr && !inc && !cma) ne = m_ac[0];
                else if (cil && !clr && !inc && !cma && !cir) ne = m_ac[15];
                else if (cle) ne = 1'b0;
                else if (cme) ne = ~m_e;
            end
            tick();
            m_ac = nac; m_e = ne;
            check_state($sformatf("b2b_state[%0d]", n), m_ac, m_e);
        end
        idle();
    endtask

    initial begin
        idle();
        ir_opcode = 3'd0; dr = 16'h0000; inpr = 8'h00; alu_sel = 2'b00;
        test_reset();
        test_decoder();
        test_int_add_and();
        test_float_directed();
        test_rotates();
        test_priority();
        test_float_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
